// File: rtl/hi_lo_mult_div_sequencer.sv
// HI/LO multi-cycle sequencer: iterative shift-add multiply and restoring
// divide sharing one 2*WIDTH working register, plus MTHI/MTLO writes.
//
// Issue handshake: start acts as "valid" and ~stall as "ready" for
// MULT/MULTU/DIV/DIVU/MTHI/MTLO. An instruction is accepted on the rising edge
// where start=1 and busy=0. While busy the issuer holds start, ALU_function and
// the operands stable. MFHI/MFLO may read hi/lo in any cycle where busy=0.
module hi_lo_mult_div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [5:0]       ALU_function,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             read_request,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   logic [1:0]         r_state;
   logic [CW-1:0]      r_count;
   logic [2*WIDTH-1:0] r_work;     // multiply: {acc, multiplier}; divide: {rem, quotient}
   logic [WIDTH-1:0]   r_opnd;     // multiplicand or divisor magnitude
   logic               r_is_div;
   logic               r_neg_lo;   // negate product / quotient
   logic               r_neg_hi;   // negate remainder (sign of dividend)
   logic               r_div0;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;

   // Issue decode and operand magnitudes
   logic               w_is_mult;
   logic               w_is_div;
   logic               w_is_signed;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_abs;
   logic [WIDTH-1:0]   w_b_abs;

   assign w_is_mult   = (ALU_function == F_MULT) || (ALU_function == F_MULTU);
   assign w_is_div    = (ALU_function == F_DIV)  || (ALU_function == F_DIVU);
   assign w_is_signed = (ALU_function == F_MULT) || (ALU_function == F_DIV);
   assign w_a_neg     = w_is_signed & operand_a[WIDTH-1];
   assign w_b_neg     = w_is_signed & operand_b[WIDTH-1];
   assign w_a_abs     = w_a_neg ? (~operand_a + 1'b1) : operand_a;
   assign w_b_abs     = w_b_neg ? (~operand_b + 1'b1) : operand_b;

   // One multiply step: conditionally add multiplicand to the upper half, then
   // shift the whole register right with the carry entering at the top.
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_mul_next;
   assign w_sum      = {1'b0, r_work[2*WIDTH-1:WIDTH]} +
                       (r_work[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
   assign w_mul_next = {w_sum, r_work[WIDTH-1:1]};

   // One restoring divide step: shift left, trial-subtract the divisor from the
   // partial remainder, keep the difference and set a quotient bit if no borrow.
   logic [WIDTH:0]     w_trial;
   logic [2*WIDTH-1:0] w_div_next;
   assign w_trial    = r_work[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
   assign w_div_next = w_trial[WIDTH] ? {r_work[2*WIDTH-2:0], 1'b0}
                                      : {w_trial[WIDTH-1:0], r_work[WIDTH-2:0], 1'b1};

   // Sign correction applied in FIX. A zero divisor yields an all-ones quotient
   // and leaves the dividend magnitude as remainder; re-applying the dividend
   // sign restores operand_a exactly.
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_q_fix;
   logic [WIDTH-1:0]   w_r_fix;
   logic [WIDTH-1:0]   w_fix_hi;
   logic [WIDTH-1:0]   w_fix_lo;
   assign w_prod_fix = r_neg_lo ? (~r_work + 1'b1) : r_work;
   assign w_q_fix    = r_div0 ? {WIDTH{1'b1}}
                              : (r_neg_lo ? (~r_work[WIDTH-1:0] + 1'b1) : r_work[WIDTH-1:0]);
   assign w_r_fix    = r_neg_hi ? (~r_work[2*WIDTH-1:WIDTH] + 1'b1) : r_work[2*WIDTH-1:WIDTH];
   assign w_fix_hi   = r_is_div ? w_r_fix : w_prod_fix[2*WIDTH-1:WIDTH];
   assign w_fix_lo   = r_is_div ? w_q_fix : w_prod_fix[WIDTH-1:0];

   // Sequencer FSM, iteration datapath and HI/LO registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_count  <= '0;
         r_work   <= '0;
         r_opnd   <= '0;
         r_is_div <= 1'b0;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
         r_div0   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (ALU_function == F_MTHI) begin
                     r_hi <= operand_a;
                  end else if (ALU_function == F_MTLO) begin
                     r_lo <= operand_a;
                  end else if (w_is_mult || w_is_div) begin
                     r_state  <= S_CALC;
                     r_count  <= '0;
                     r_is_div <= w_is_div;
                     r_work   <= {{WIDTH{1'b0}}, (w_is_div ? w_a_abs : w_b_abs)};
                     r_opnd   <= w_is_div ? w_b_abs : w_a_abs;
                     r_neg_lo <= w_a_neg ^ w_b_neg;
                     r_neg_hi <= w_a_neg;
                     r_div0   <= w_is_div && (operand_b == '0);
                  end
               end
            end
            S_CALC: begin
               r_work  <= r_is_div ? w_div_next : w_mul_next;
               r_count <= r_count + 1'b1;
               if (r_count == LAST) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_hi    <= w_fix_hi;
               r_lo    <= w_fix_lo;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign stall     = (start | read_request) & busy;
   assign done      = r_done;
   assign hi        = r_hi;
   assign lo        = r_lo;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_hi_lo_mult_div_sequencer.sv
// Bench for hi_lo_mult_div_sequencer: directed corner cases with literal
// expectations, then randomized issue traffic against a countdown model.
module tb_hi_lo_mult_div_sequencer;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_BAD   = 6'b100000;

   // clock / reset
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   always #5 clk = ~clk;

   logic        start = 1'b0;
   logic [5:0]  ALU_function = '0;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        read_request = 1'b0;
   logic        busy, stall, done;
   logic [31:0] hi, lo;
   logic [1:0]  dbg_state;

   hi_lo_mult_div_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .ALU_function(ALU_function),
      .operand_a(operand_a), .operand_b(operand_b), .read_request(read_request),
      .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo),
      .dbg_state(dbg_state)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result {hi,lo} from plain arithmetic
   function automatic logic [63:0] model_result(input logic [5:0] f, input logic [31:0] a,
                                                input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] ua, ub, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      model_result = '0;
      case (f)
         F_MULT:  model_result = sa * sb;
         F_MULTU: model_result = ua * ub;
         F_DIV, F_DIVU: begin
            if (b == 32'd0) begin
               model_result = {a, 32'hFFFFFFFF};
            end else if (f == F_DIV) begin
               q = sa / sb;
               r = sa % sb;
               model_result = {r[31:0], q[31:0]};
            end else begin
               q = ua / ub;
               r = ua % ub;
               model_result = {r[31:0], q[31:0]};
            end
         end
         default: model_result = '0;
      endcase
   endfunction

   // Behavioural model: an accepted MULT/DIV makes the unit busy for 33 cycles,
   // then hi/lo take the result and done shows for one cycle.
   logic [31:0] m_hi = '0, m_lo = '0;
   logic [63:0] m_pend = '0;
   int          m_left = 0;
   logic        m_done = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_hi   <= '0;
         m_lo   <= '0;
         m_left <= 0;
         m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_hi   <= m_pend[63:32];
               m_lo   <= m_pend[31:0];
               m_done <= 1'b1;
            end
         end else if (start) begin
            case (ALU_function)
               F_MTHI: m_hi <= operand_a;
               F_MTLO: m_lo <= operand_a;
               F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                  m_pend <= model_result(ALU_function, operand_a, operand_b);
                  m_left <= 33;
               end
               default: ;
            endcase
         end
      end
   end

   // scoreboard compare: every cycle, away from the clock edges
   always begin
      @(negedge clk);
      #2;
      check("busy",  {31'd0, busy},  {31'd0, (m_left != 0)});
      check("stall", {31'd0, stall}, {31'd0, ((start | read_request) && (m_left != 0))});
      check("done",  {31'd0, done},  {31'd0, m_done});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
   end

   // driver: called just after a negedge; holds start until accepted
   task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      bit acc;
      int n;
      ALU_function = f;
      operand_a    = a;
      operand_b    = b;
      start        = 1'b1;
      n = 0;
      forever begin
         acc = (m_left == 0);
         @(posedge clk);
         n++;
         if (acc) break;
         if (n > 100) begin
            check("accept_timeout", 32'(n), 32'd0);
            break;
         end
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   // counts busy cycles from the current negedge until the unit is idle
   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (busy && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
      if (cnt >= 200) check("idle_timeout", 32'(cnt), 32'd0);
   endtask

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 5))
         0: rand_val = 32'd0;
         1: rand_val = 32'hFFFFFFFF;
         2: rand_val = 32'h80000000;
         3: rand_val = 32'($urandom_range(0, 20));
         default: rand_val = $urandom;
      endcase
   endfunction

   // watchdog
   initial begin
      #500000;
      n_errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // main sequence
   initial begin
      int cnt;
      logic [5:0] f;
      logic [5:0] ftab [7];
      ftab = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_BAD};

      repeat (3) @(negedge clk);
      #2;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      @(negedge clk);
      #3 reset_n = 1'b1;
      @(negedge clk);

      // MULTU max*max, 33 busy cycles, done in the first idle cycle
      do_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_idle(cnt);
      check("multu_busy_cycles", 32'(cnt), 32'd33);
      check("multu_done", {31'd0, done}, 32'd1);
      check("multu_hi", hi, 32'hFFFFFFFE);
      check("multu_lo", lo, 32'h00000001);

      // MULT -3*5, then DIVU held with read_request through busy
      do_op(F_MULT, 32'hFFFFFFFD, 32'd5);
      read_request = 1'b1;
      do_op(F_DIVU, 32'd100, 32'd7);
      read_request = 1'b0;
      check("mult_hi", hi, 32'hFFFFFFFF);
      check("mult_lo", lo, 32'hFFFFFFF1);
      wait_idle(cnt);
      check("divu_hi", hi, 32'd2);
      check("divu_lo", lo, 32'd14);

      do_op(F_MULTU, 32'hFFFFFFFD, 32'd5);
      wait_idle(cnt);
      check("multu2_hi", hi, 32'h00000004);
      check("multu2_lo", lo, 32'hFFFFFFF1);

      do_op(F_DIV, 32'hFFFFFFF9, 32'd2);
      wait_idle(cnt);
      check("div_neg_hi", hi, 32'hFFFFFFFF);
      check("div_neg_lo", lo, 32'hFFFFFFFD);

      do_op(F_DIVU, 32'd5, 32'd0);
      wait_idle(cnt);
      check("div0_busy_cycles", 32'(cnt), 32'd33);
      check("div0_hi", hi, 32'd5);
      check("div0_lo", lo, 32'hFFFFFFFF);

      do_op(F_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_idle(cnt);
      check("div_ovf_hi", hi, 32'd0);
      check("div_ovf_lo", lo, 32'h80000000);

      // MTLO with a simultaneous read in IDLE: accepted, never busy
      read_request = 1'b1;
      do_op(F_MTLO, 32'h1234, 32'd0);
      read_request = 1'b0;
      check("mtlo_lo", lo, 32'h1234);
      wait_idle(cnt);
      check("mtlo_busy_cycles", 32'(cnt), 32'd0);

      do_op(F_BAD, 32'hDEADBEEF, 32'd1);
      wait_idle(cnt);
      check("bad_funct_busy_cycles", 32'(cnt), 32'd0);

      // asynchronous reset in the middle of CALC
      do_op(F_MULT, 32'd7, 32'd9);
      repeat (9) @(negedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_hi", hi, 32'd0);
      check("arst_lo", lo, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      #3 reset_n = 1'b1;
      do_op(F_DIVU, 32'd9, 32'd3);
      wait_idle(cnt);
      check("post_rst_hi", hi, 32'd0);
      check("post_rst_lo", lo, 32'd3);

      // randomized traffic, sometimes back-to-back
      for (int i = 0; i < 30; i++) begin
         f = ftab[$urandom_range(0, 6)];
         read_request = 1'($urandom_range(0, 1));
         do_op(f, rand_val(), rand_val());
         read_request = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) != 0) begin
            wait_idle(cnt);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
      read_request = 1'b0;
      wait_idle(cnt);
      repeat (2) @(negedge clk);
      #3;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
